// File: rtl/xperm_arb_rv64.sv
// Round-robin arbiter for two requesters sharing one xperm8/xperm4 datapath,
// with a one-entry registered result buffer (1-cycle latency, pop-and-accept allowed).
module xperm_arb_rv64 #(
  parameter int TAG_W = 4
) (
  input  logic             g_clk,
  input  logic             g_resetn,
  input  logic             flush,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_op,
  input  logic [63:0]      req0_rs1,
  input  logic [63:0]      req0_rs2,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_op,
  input  logic [63:0]      req1_rs1,
  input  logic [63:0]      req1_rs2,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_rd,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag
);

  logic             last_grant;
  logic             grant;
  logic             can_accept;
  logic             fire;
  logic             op;
  logic [63:0]      rs1;
  logic [63:0]      rs2;
  logic [63:0]      rd;
  logic [TAG_W-1:0] tag;

  assign can_accept = !flush && (!rsp_valid || rsp_ready);
  // A lone requester wins outright; contention goes to whoever did not win last.
  assign grant      = (req0_valid && req1_valid) ? !last_grant : req1_valid;
  assign req0_ready = can_accept && !grant;
  assign req1_ready = can_accept && grant;
  assign fire       = grant ? (req1_valid && req1_ready) : (req0_valid && req0_ready);

  assign op  = grant ? req1_op  : req0_op;
  assign rs1 = grant ? req1_rs1 : req0_rs1;
  assign rs2 = grant ? req1_rs2 : req0_rs2;
  assign tag = grant ? req1_tag : req0_tag;

  always_comb begin
    rd = '0;
    if (op) begin
      for (int i = 0; i < 16; i++)
        rd[4*i +: 4] = rs2[{rs1[4*i +: 4], 2'b00} +: 4];
    end else begin
      // Full 8-bit index is range-checked; anything >= 8 yields a zero byte.
      for (int i = 0; i < 8; i++)
        if (rs1[8*i +: 8] < 8'd8)
          rd[8*i +: 8] = rs2[{rs1[8*i +: 3], 3'b000} +: 8];
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      rsp_valid  <= 1'b0;
      rsp_rd     <= '0;
      rsp_id     <= 1'b0;
      rsp_tag    <= '0;
      last_grant <= 1'b1;
    end else if (flush) begin
      rsp_valid <= 1'b0;
    end else if (fire) begin
      rsp_valid  <= 1'b1;
      rsp_rd     <= rd;
      rsp_id     <= grant;
      rsp_tag    <= tag;
      last_grant <= grant;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: doc/xperm_arb_rv64.md
Name: xperm_arb_rv64

Overview:
- Two-requester arbiter and result buffer around a single shared 64-bit crossbar-permutation datapath (xperm8 and xperm4) in the crypto FU.
- Each requester presents an operation over a valid/ready handshake. The arbiter grants one per cycle, round-robin, and computes the permutation combinationally.
- The result is registered into a one-entry output buffer, returned with requester id and tag over a valid/ready response port.
- Sits between the two issue slots and the FU writeback mux.

Parameters:
- TAG_W, 4, width of the opaque requester tag carried from request to response.

Ports:
- g_clk  in  1  clock; all state updates on rising edge.
- g_resetn  in  1  reset, asynchronous assert, active-low.
- flush  in  1  synchronous flush; drops buffered result, blocks acceptance this cycle.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  1  0 = xperm8, 1 = xperm4.
- req0_rs1  in  64  index operand.
- req0_rs2  in  64  lookup-table operand.
- req0_tag  in  TAG_W  opaque tag.
- req1_valid, req1_ready, req1_op, req1_rs1, req1_rs2, req1_tag: as req0, for requester 1.
- rsp_valid  out  1  result buffer holds a result.
- rsp_ready  in  1  consumer takes result this cycle.
- rsp_rd  out  64  permutation result.
- rsp_id  out  1  requester that issued the result.
- rsp_tag  out  TAG_W  tag of that request.

Behaviour:
- Reset (g_resetn low, asynchronous):
  - rsp_valid=0, rsp_rd=0, rsp_id=0, rsp_tag=0.
  - last_grant=1, so requester 0 wins first.
  - Any buffered result is discarded.
- Buffer availability: can_accept = !flush && (!rsp_valid || rsp_ready). Pass-through-on-pop is allowed: accept and drain in the same cycle.
- Arbitration (combinational, within one cycle):
  - Only req0_valid: grant 0. Only req1_valid: grant 1.
  - Both valid: grant the requester != last_grant.
  - reqN_ready = can_accept && grant==N. At most one ready is high per cycle.
  - readyN does not depend on reqN_valid of the same requester beyond the grant rule.
- last_grant updates only on an accepted transfer (valid && ready). Stalled cycles do not rotate priority.
- Datapath, applied to the granted operands:
  - xperm8: for byte i in 0..7, idx = rs1[8i+:8]; rd[8i+:8] = (idx<8) ? rs2[8*idx+:8] : 8'h00. Out-of-range indices produce zero; the full 8-bit index is compared, not truncated.
  - xperm4: for nibble i in 0..15, idx = rs1[4i+:4]; rd[4i+:4] = rs2[4*idx+:4]. All 16 indices are in range.
- Latency: exactly 1 cycle. An accepted request in cycle N gives rsp_valid=1 in cycle N+1, with rd, id and tag registered.
- Response hold:
  - While rsp_valid && !rsp_ready, rsp_rd, rsp_id and rsp_tag hold stable and both req*_ready are 0.
  - rsp_valid is cleared on pop unless a new accept occurs in the same cycle.
- Flush:
  - rsp_valid goes to 0 next cycle; data fields may hold stale values.
  - No request is accepted in the flush cycle, and last_grant is unchanged.
  - Flush has priority over rsp_ready and request acceptance.
- Throughput: one operation per cycle sustained while rsp_ready=1.
- Requester inputs are sampled only in the accept cycle. A requester may drop or change valid/operands while not ready; the arbiter must tolerate this and takes no action.
- Reset asserted mid-operation: the buffered result is lost, with no partial response. After deassertion, the first grant goes to requester 0.

Test Plan:
- Single xperm8: req0 op=0, rs2=0x0706050403020100, rs1=0x0001020304050607, tag=3 → next cycle rsp_valid=1, rsp_rd=0x0001020304050607, rsp_id=0, rsp_tag=3.
- xperm8 out-of-range: rs2=0x8877665544332211, rs1=0x0000000000000008 → rsp_rd=0x1111111111111100. Also rs1 byte0=0x80 → byte0=0x00.
- xperm4 via req1: rs2=0xFEDCBA9876543210, rs1=0x0123456789ABCDEF → rsp_rd=0x0123456789ABCDEF, rsp_id=1.
- Round-robin: both valid for 4 cycles after reset, rsp_ready=1 → grants 0,1,0,1; rsp_id sequence 0,1,0,1 in cycles 1-4; one response per cycle.
- Backpressure:
  - Buffer full, rsp_ready=0 for 3 cycles with both requesters valid → both ready=0; rsp fields stable; last_grant unchanged.
  - Then rsp_ready=1 → pop and new accept in the same cycle.
- Flush and reset:
  - flush with rsp_valid=1 and req0 valid → rsp_valid=0 next cycle, req0_ready=0 in the flush cycle.
  - g_resetn pulsed low mid-stream → rsp_valid=0 immediately; first post-reset grant goes to req0.
